// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding select and load-use stall detection against a two-entry MEM/WB shadow pipe.
// Zero-latency combinational outputs; stall is the only backpressure, one cycle per load-use hazard.
module fwd_hazard_unit #(
  parameter logic [4:0]  LOAD_OPC = 5'b10001,
  parameter logic [2:0]  LINK_REG = 3'd7,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ex_instr,
  input  logic             ex_valid,
  input  logic             ex_regwrt,
  input  logic [2:0]       rs,
  input  logic [2:0]       rt,
  input  logic             rs_v,
  input  logic             rt_v,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_rs_v,
  input  logic             id_rt_v,
  output logic [1:0]       forward_A,
  output logic [1:0]       forward_B,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  logic [4:0] op;
  logic       dec_wr;
  logic [2:0] dec_rd;
  logic       ex_wr;
  logic       ex_ld;

  logic       mem_v;
  logic [2:0] mem_rd;
  logic       mem_ld;
  logic       wb_v;
  logic [2:0] wb_rd;

  // Low instruction bits never name a destination.
  logic       unused_bits;
  assign unused_bits = ^ex_instr[1:0];

  assign op = ex_instr[15:11];

  always_comb begin
    dec_wr = 1'b1;
    dec_rd = 3'd0;
    casez (op)
      5'b1101?, 5'b111??, 5'b11001: dec_rd = ex_instr[4:2];
      5'b010??, 5'b101??, 5'b10001: dec_rd = ex_instr[7:5];
      5'b10011, 5'b11000, 5'b10010: dec_rd = ex_instr[10:8];
      5'b0011?:                     dec_rd = LINK_REG;
      default:                      dec_wr = 1'b0;
    endcase
  end

  assign ex_wr = ex_valid & ex_regwrt & dec_wr;
  assign ex_ld = ex_wr & (op == LOAD_OPC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_v  <= 1'b0;
      mem_rd <= 3'd0;
      mem_ld <= 1'b0;
      wb_v   <= 1'b0;
      wb_rd  <= 3'd0;
    end else begin
      mem_v  <= ex_wr;
      mem_rd <= dec_rd;
      mem_ld <= ex_ld;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
    end
  end

  // A load in MEM only has its address on the ALU bus, so it is skipped and WB is consulted instead.
  assign forward_A = (rs_v & mem_v & ~mem_ld & (rs == mem_rd)) ? 2'b10 :
                     (rs_v & wb_v  & (rs == wb_rd))            ? 2'b01 : 2'b00;
  assign forward_B = (rt_v & mem_v & ~mem_ld & (rt == mem_rd)) ? 2'b10 :
                     (rt_v & wb_v  & (rt == wb_rd))            ? 2'b01 : 2'b00;

  assign stall = rst & ex_ld & ((id_rs_v & (id_rs == dec_rd)) | (id_rt_v & (id_rt == dec_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random checks of fwd_hazard_unit against a history-of-writes reference model.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic [15:0] ex_instr;
  logic        ex_valid, ex_regwrt;
  logic [2:0]  rs, rt, id_rs, id_rt;
  logic        rs_v, rt_v, id_rs_v, id_rt_v;
  logic [1:0]  forward_A, forward_B;
  logic        stall;
  logic [15:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference: the last two instructions that left EX (index 0 = one cycle ago, 1 = two cycles ago).
  bit       hv  [2];
  bit [2:0] hrd [2];
  bit       hld [2];
  int       exp_cnt;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .ex_instr(ex_instr), .ex_valid(ex_valid), .ex_regwrt(ex_regwrt),
    .rs(rs), .rt(rt), .rs_v(rs_v), .rt_v(rt_v), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_v(id_rs_v), .id_rt_v(id_rt_v), .forward_A(forward_A), .forward_B(forward_B),
    .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dest_of(input logic [15:0] ins);
    logic [4:0] o;
    o = ins[15:11];
    if (o inside {5'b11010, 5'b11011, 5'b11001} || o[4:2] == 3'b111) return {1'b1, ins[4:2]};
    if (o[4:2] == 3'b010 || o[4:2] == 3'b101 || o == 5'b10001)      return {1'b1, ins[7:5]};
    if (o inside {5'b10011, 5'b11000, 5'b10010})                   return {1'b1, ins[10:8]};
    if (o inside {5'b00110, 5'b00111})                             return {1'b1, 3'd7};
    return 4'b0000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic v, input logic [2:0] r);
    if (v && hv[0] && !hld[0] && r == hrd[0]) return 2'b10;
    if (v && hv[1] && r == hrd[1])            return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    logic [3:0] d;
    logic       ld;
    d  = dest_of(ex_instr);
    ld = ex_valid && ex_regwrt && d[3] && (ex_instr[15:11] == 5'b10001);
    return rst && ld && ((id_rs_v && id_rs == d[2:0]) || (id_rt_v && id_rt == d[2:0]));
  endfunction

  task automatic model_reset();
    hv = '{0, 0};
    hld = '{0, 0};
    hrd = '{0, 0};
    exp_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ins, input logic v, input logic w,
                       input logic [2:0] a, input logic [2:0] b, input logic av, input logic bv,
                       input logic [2:0] ia, input logic [2:0] ib, input logic iav, input logic ibv);
    ex_instr = ins; ex_valid = v; ex_regwrt = w;
    rs = a; rt = b; rs_v = av; rt_v = bv;
    id_rs = ia; id_rt = ib; id_rs_v = iav; id_rt_v = ibv;
  endtask

  // Advance one clock, updating the model with the inputs the DUT samples at that edge.
  task automatic tick();
    logic [3:0] d;
    logic       wr, st;
    @(posedge clk);
    if (rst) begin
      d  = dest_of(ex_instr);
      wr = ex_valid && ex_regwrt && d[3];
      st = exp_stall();
      if (st && exp_cnt < 65535) exp_cnt++;
      hv[1] = hv[0]; hrd[1] = hrd[0]; hld[1] = hld[0];
      hv[0] = wr; hrd[0] = d[2:0]; hld[0] = wr && (ex_instr[15:11] == 5'b10001);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_fwdA"}, 16'(forward_A), 16'(exp_fwd(rs_v, rs)));
    chk({tag, "_fwdB"}, 16'(forward_B), 16'(exp_fwd(rt_v, rt)));
    chk({tag, "_stall"}, 16'(stall), 16'(exp_stall()));
    chk({tag, "_cnt"}, stall_count, 16'(exp_cnt));
  endtask

  localparam logic [4:0] RND_OPS [11] = '{5'b11011, 5'b11100, 5'b11001, 5'b01001, 5'b10100,
                                          5'b10001, 5'b10011, 5'b11000, 5'b00110, 5'b00000, 5'b10000};

  initial begin
    rst = 1'b0;
    model_reset();
    drive(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    // Hazard-shaped inputs while in reset must not produce a stall.
    drive(16'h8940, 1, 1, 3'd2, 3'd2, 1, 1, 3'd2, 3'd2, 1, 1);
    #2;
    chk("rst_fwdA", 16'(forward_A), 16'h0);
    chk("rst_fwdB", 16'(forward_B), 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    chk("rst_cnt", stall_count, 16'h0);
    @(negedge clk);
    drive(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();

    // ADD r3 then SUB r4,r3,r3
    drive(16'hD94C, 1, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); #1; check_model("add"); tick();
    drive(16'hD950, 1, 1, 3'd3, 3'd3, 1, 1, 0, 0, 0, 0); #1;
    chk("sub_fwdA", 16'(forward_A), 16'h2);
    chk("sub_fwdB", 16'(forward_B), 16'h2);
    tick();

    // ADD r3, NOP, read r3 -> WB forward
    drive(16'hD94C, 1, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    drive(16'h0800, 1, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0); tick();
    drive(16'h0800, 1, 1, 3'd3, 3'd5, 1, 1, 0, 0, 0, 0); #1;
    chk("wb_fwdA", 16'(forward_A), 16'h1);
    chk("wb_fwdB", 16'(forward_B), 16'h0);
    tick();

    // ADD r3, ADD r3, read r3 -> MEM wins over WB
    drive(16'hD94C, 1, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    drive(16'hD94C, 1, 1, 3'd3, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    drive(16'h0800, 1, 1, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("prio_fwdA", 16'(forward_A), 16'h2);
    tick();

    // Load-use: stall, bubble, dependent forwarded from WB
    drive(16'h8940, 1, 1, 3'd1, 3'd0, 1, 0, 3'd2, 3'd5, 1, 0); #1;
    chk("ld_stall", 16'(stall), 16'h1);
    check_model("ld");
    tick();
    drive(16'h8940, 0, 1, 3'd1, 3'd0, 0, 0, 3'd2, 3'd5, 1, 0); #1;
    chk("bubble_stall", 16'(stall), 16'h0);
    tick();
    drive(16'hD94C, 1, 1, 3'd2, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("dep_fwdA", 16'(forward_A), 16'h1);
    chk("dep_stall", 16'(stall), 16'h0);
    chk("dep_cnt", stall_count, 16'h1);
    tick();

    // JAL then JR r7
    drive(16'h3000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(16'h0000, 1, 1, 3'd7, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("jr_fwdA", 16'(forward_A), 16'h2);
    tick();

    // ST writes nothing: never forwards, from MEM or WB
    drive(16'h8000, 1, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    drive(16'h0000, 1, 1, 3'd0, 3'd0, 1, 1, 0, 0, 0, 0); #1;
    chk("st_mem_fwdA", 16'(forward_A), 16'h0);
    chk("st_mem_fwdB", 16'(forward_B), 16'h0);
    tick();
    drive(16'h0000, 1, 1, 3'd0, 3'd0, 1, 1, 0, 0, 0, 0); #1;
    chk("st_wb_fwdA", 16'(forward_A), 16'h0);
    tick();

    // Flushed ADD r3 never forwards
    drive(16'hD94C, 0, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    drive(16'h0000, 1, 1, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("flush1_fwdA", 16'(forward_A), 16'h0);
    tick();
    drive(16'h0000, 1, 1, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("flush2_fwdA", 16'(forward_A), 16'h0);
    tick();

    // RegWrt low suppresses the write
    drive(16'hD94C, 1, 0, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    drive(16'h0000, 1, 1, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("nowrt_fwdA", 16'(forward_A), 16'h0);
    tick();

    // r0 forwards like any other register
    drive(16'hD800, 1, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    drive(16'h0000, 1, 1, 3'd0, 3'd0, 1, 1, 0, 0, 0, 0); #1;
    chk("r0_fwdA", 16'(forward_A), 16'h2);
    chk("r0_fwdB", 16'(forward_B), 16'h2);
    tick();

    // Load in MEM is skipped; older ALU write of same reg in WB is used
    drive(16'hD808, 1, 1, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0); tick();
    drive(16'h8940, 1, 1, 3'd1, 3'd1, 1, 0, 0, 0, 0, 0); tick();
    drive(16'h0000, 1, 1, 3'd2, 3'd2, 1, 1, 0, 0, 0, 0); #1;
    chk("ldmem_fwdA", 16'(forward_A), 16'h1);
    chk("ldmem_fwdB", 16'(forward_B), 16'h1);
    tick();

    // Mid-run reset discards tracked destinations immediately
    drive(16'hD94C, 1, 1, 3'd1, 3'd2, 1, 1, 0, 0, 0, 0); tick();
    rst = 1'b0;
    model_reset();
    drive(16'h0000, 1, 1, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("midrst_fwdA", 16'(forward_A), 16'h0);
    chk("midrst_cnt", stall_count, 16'h0);
    #2;
    rst = 1'b1;
    tick();
    drive(16'h0000, 1, 1, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0); #1;
    chk("postrst_fwdA", 16'(forward_A), 16'h0);
    tick();

    // Random traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      drive({RND_OPS[$urandom_range(0, 10)], 11'($urandom)},
            $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
            3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check_model("rnd");
      tick();
    end

    // Saturation: continuous load-use hazard via the ID rt field
    rst = 1'b0;
    model_reset();
    drive(16'h8940, 1, 1, 0, 0, 0, 0, 3'd0, 3'd2, 0, 1);
    #1;
    chk("sat_rst_stall", 16'(stall), 16'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("sat_rt_stall", 16'(stall), 16'h1);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_cnt_fffe", stall_count, 16'hFFFE);
    repeat (3) tick();
    chk("sat_cnt_ffff", stall_count, 16'hFFFF);
    chk("sat_model_cnt", stall_count, 16'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
